// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter (instruction fetch vs. load/store) in front of one single-port RAM.
// Load/store has priority; a starvation counter forces a fetch grant after STARVE_LIMIT wins.
module ram_port_arbiter #(
    parameter int unsigned STARVE_LIMIT = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_req,
    input  logic [7:0]  if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [7:0]  ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_gnt,
    output logic        ls_rvalid,
    output logic [31:0] ls_rdata,
    output logic [7:0]  ram_addr,
    output logic [31:0] ram_data,
    output logic        ram_we,
    input  logic [31:0] ram_q
);

    localparam logic [2:0] Limit = 3'(STARVE_LIMIT);

    logic [2:0] starve_cnt_q, starve_cnt_d;
    logic       if_rvalid_q, if_rvalid_d;
    logic       ls_rvalid_q, ls_rvalid_d;
    logic       fetch_forced;

    // Grants are masked while reset is asserted so nothing reaches the RAM.
    always_comb begin
        fetch_forced = if_req && (starve_cnt_q == Limit);
        ls_gnt       = rst_n && ls_req && !fetch_forced;
        if_gnt       = rst_n && if_req && !ls_gnt;
    end

    always_comb begin
        ram_addr = 8'h00;
        ram_data = 32'h0;
        ram_we   = 1'b0;
        if (ls_gnt) begin
            ram_addr = ls_addr;
            ram_data = ls_wdata;
            ram_we   = ls_we;
        end else if (if_gnt) begin
            ram_addr = if_addr;
        end
    end

    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (ls_gnt && if_req) begin
            if (starve_cnt_q != Limit) begin
                starve_cnt_d = starve_cnt_q + 3'd1;
            end
        end else if (if_gnt || !if_req) begin
            starve_cnt_d = 3'd0;
        end
    end

    // Response tags follow the registered RAM read by exactly one cycle.
    always_comb begin
        if_rvalid_d = if_gnt;
        ls_rvalid_d = ls_gnt && !ls_we;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            starve_cnt_q <= 3'd0;
            if_rvalid_q  <= 1'b0;
            ls_rvalid_q  <= 1'b0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            if_rvalid_q  <= if_rvalid_d;
            ls_rvalid_q  <= ls_rvalid_d;
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign ls_rvalid = ls_rvalid_q;
    assign if_rdata  = ram_q;
    assign ls_rdata  = ram_q;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a behavioural registered-read RAM behind it.
module tb_ram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, ls_req, ls_we;
    logic [7:0]  if_addr, ls_addr;
    logic [31:0] ls_wdata;
    logic        if_gnt, if_rvalid, ls_gnt, ls_rvalid, ram_we;
    logic [31:0] if_rdata, ls_rdata, ram_data, ram_q;
    logic [7:0]  ram_addr;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    ram_port_arbiter #(.STARVE_LIMIT(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_gnt(ls_gnt), .ls_rvalid(ls_rvalid), .ls_rdata(ls_rdata),
        .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q)
    );

    // Unwritten locations return a fixed address-derived pattern.
    function automatic logic [31:0] pat(input logic [7:0] a);
        if (a == 8'h05) return 32'h0780_3204;
        return {8'hA5, a, ~a, a};
    endfunction

    logic [31:0] mem [256];
    bit   [255:0] written;

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr]     <= ram_data;
            written[ram_addr] <= 1'b1;
        end
        ram_q <= written[ram_addr] ? mem[ram_addr] : pat(ram_addr);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic ir, input logic [7:0] ia, input logic lr, input logic lw,
                         input logic [7:0] la, input logic [31:0] wd);
        if_req   = ir;
        if_addr  = ia;
        ls_req   = lr;
        ls_we    = lw;
        ls_addr  = la;
        ls_wdata = wd;
        #1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 32'h0);
    endtask

    initial begin
        logic exp_ls;
        logic prev_fetch;
        logic [7:0] prev_addr;

        rst_n = 1'b0;
        idle();
        #1;
        // Requests during reset must be masked.
        drive(1'b1, 8'h22, 1'b1, 1'b1, 8'h33, 32'h1234_5678);
        check_eq("rst_gnts", {30'h0, if_gnt, ls_gnt}, 32'h0);
        check_eq("rst_ram_we", {31'h0, ram_we}, 32'h0);
        check_eq("rst_ram_addr", {24'h0, ram_addr}, 32'h0);
        check_eq("rst_ram_data", ram_data, 32'h0);
        check_eq("rst_rvalid", {30'h0, if_rvalid, ls_rvalid}, 32'h0);
        idle();
        @(posedge clk);
        #1 rst_n = 1'b1;

        // Fetch-only read, granted in first cycle after reset.
        drive(1'b1, 8'h05, 1'b0, 1'b0, 8'h00, 32'h0);
        check_eq("f_if_gnt", {31'h0, if_gnt}, 32'h1);
        check_eq("f_ls_gnt", {31'h0, ls_gnt}, 32'h0);
        check_eq("f_ram_addr", {24'h0, ram_addr}, 32'h05);
        check_eq("f_ram_we", {31'h0, ram_we}, 32'h0);
        next_cycle();
        idle();
        check_eq("f_rvalid_n1", {30'h0, if_rvalid, ls_rvalid}, 32'h2);
        check_eq("f_rdata", if_rdata, 32'h0780_3204);
        next_cycle();
        idle();
        check_eq("f_rvalid_n2", {30'h0, if_rvalid, ls_rvalid}, 32'h0);

        // Store then load same address.
        next_cycle();
        drive(1'b0, 8'h00, 1'b1, 1'b1, 8'h10, 32'hDEAD_BEEF);
        check_eq("st_gnt", {30'h0, if_gnt, ls_gnt}, 32'h1);
        check_eq("st_ram_we", {31'h0, ram_we}, 32'h1);
        check_eq("st_ram_addr", {24'h0, ram_addr}, 32'h10);
        check_eq("st_ram_data", ram_data, 32'hDEAD_BEEF);
        next_cycle();
        drive(1'b0, 8'h00, 1'b1, 1'b0, 8'h10, 32'h0);
        check_eq("ld_gnt", {30'h0, if_gnt, ls_gnt}, 32'h1);
        check_eq("ld_ram_we", {31'h0, ram_we}, 32'h0);
        check_eq("st_no_rvalid", {30'h0, if_rvalid, ls_rvalid}, 32'h0);
        next_cycle();
        idle();
        check_eq("ld_rvalid", {30'h0, if_rvalid, ls_rvalid}, 32'h1);
        check_eq("ld_rdata", ls_rdata, 32'hDEAD_BEEF);

        // Contention: ls,ls,ls,if repeating.
        for (int k = 0; k < 8; k++) begin
            next_cycle();
            drive(1'b1, 8'h01, 1'b1, 1'b0, 8'h82, 32'h0);
            exp_ls = (k % 4) != 3;
            check_eq($sformatf("cont_ls_gnt%0d", k), {31'h0, ls_gnt}, {31'h0, exp_ls});
            check_eq($sformatf("cont_if_gnt%0d", k), {31'h0, if_gnt}, {31'h0, !exp_ls});
        end
        next_cycle();
        idle();

        // Alternating fetch / load, one response per cycle.
        prev_fetch = 1'b0;
        prev_addr  = 8'h00;
        for (int k = 0; k < 9; k++) begin
            next_cycle();
            if (k == 8) begin
                idle();
            end else if (k % 2 == 0) begin
                drive(1'b1, 8'(k / 2), 1'b0, 1'b0, 8'h00, 32'h0);
                check_eq($sformatf("alt_if_gnt%0d", k), {30'h0, if_gnt, ls_gnt}, 32'h2);
            end else begin
                drive(1'b0, 8'h00, 1'b1, 1'b0, 8'(8'h80 + k / 2), 32'h0);
                check_eq($sformatf("alt_ls_gnt%0d", k), {30'h0, if_gnt, ls_gnt}, 32'h1);
            end
            if (k > 0) begin
                check_eq($sformatf("alt_rvalid%0d", k), {30'h0, if_rvalid, ls_rvalid},
                         prev_fetch ? 32'h2 : 32'h1);
                check_eq($sformatf("alt_rdata%0d", k), prev_fetch ? if_rdata : ls_rdata,
                         pat(prev_addr));
            end
            prev_fetch = (k % 2 == 0);
            prev_addr  = (k % 2 == 0) ? 8'(k / 2) : 8'(8'h80 + k / 2);
        end

        // Reset between a load grant and its response.
        next_cycle();
        drive(1'b1, 8'h00, 1'b1, 1'b0, 8'h80, 32'h0);
        check_eq("rr_ls_gnt", {30'h0, if_gnt, ls_gnt}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("rr_rvalid_async", {30'h0, if_rvalid, ls_rvalid}, 32'h0);
        check_eq("rr_gnt_masked", {30'h0, if_gnt, ls_gnt}, 32'h0);
        check_eq("rr_addr_masked", {24'h0, ram_addr}, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        #1;
        check_eq("rr_rvalid_after", {30'h0, if_rvalid, ls_rvalid}, 32'h0);
        check_eq("rr_c0", {30'h0, if_gnt, ls_gnt}, 32'h1);
        for (int k = 1; k < 4; k++) begin
            next_cycle();
            check_eq($sformatf("rr_c%0d", k), {30'h0, if_gnt, ls_gnt}, (k == 3) ? 32'h2 : 32'h1);
        end

        // Idle.
        next_cycle();
        idle();
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            idle();
            check_eq($sformatf("idle%0d", k),
                     {20'h0, if_gnt, ls_gnt, if_rvalid, ls_rvalid, ram_we, 3'b0, ram_addr} |
                     ram_data, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
